// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//
// Contents:
//   state_t        FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  default operand/result width
//   count_width()  bit counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must hold the values 0 .. width-1.
    // Width is at least 2, so the result is never below 1 bit.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: computes a - b - bin.
//
// Ports:
//   a     in   minuend bit
//   b     in   subtrahend bit
//   bin   in   borrow in
//   d     out  difference bit
//   bout  out  borrow out
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // A borrow is generated when b exceeds a.
    // An incoming borrow is passed on when a equals b.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor computing inA - inB.
// It processes one bit per clock, LSB first, under a start/done handshake.
// A start accepted at edge 0 runs over edges 1..WIDTH.
// done pulses in the cycle after edge WIDTH.
//
// Optional feature macro: SERIAL_SUB_FLAGS_EN adds the zero and overflow flags.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request a subtraction (ignored while busy)
//   inA         in   minuend, captured on the accepted start edge
//   inB         in   subtrahend, captured on the accepted start edge
//   busy        out  high while the RUN state is active
//   done        out  one-cycle pulse when the result is ready
//   diff        out  inA - inB modulo 2^WIDTH, held until the next result
//   borrow_out  out  1 when inA < inB (unsigned)
//   zero        out  diff == 0                  (SERIAL_SUB_FLAGS_EN only)
//   overflow    out  signed overflow of inA-inB (SERIAL_SUB_FLAGS_EN only)
module serial_subtractor_8bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic             bit_d;
    logic             bit_bout;
    logic             accept;
    logic             last_bit;

    // A single cell is shared by every bit position.
    // The operand LSBs are shifted into it one cycle at a time.
    full_subtractor_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign accept   = (state != RUN) && start;
    assign last_bit = (state == RUN) && (count == LAST);

    // Partial result with the new bit shifted in at the MSB.
    // After the last bit it is the complete difference.
    assign res_next = {bit_d, res_sh};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A start during the DONE cycle goes straight back to RUN, which allows
    // back-to-back operations.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand shift registers, the borrow chain and the bit counter.
    // The partial result builds up in res_sh. It is copied to diff only on the
    // final bit, so the previous result stays visible while the next one runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= inA;
            b_sh  <= inB;
            br    <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            br     <= bit_bout;
            count  <= count + CW'(1);
            if (last_bit) begin
                diff       <= res_next;
                borrow_out <= bit_bout;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic a_msb;
    logic b_msb;

    // Flags are taken from the operand MSBs saved at start and the final
    // difference bit. They update on the same edge as diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (accept) begin
            a_msb <= inA[WIDTH-1];
            b_msb <= inB[WIDTH-1];
        end else if (last_bit) begin
            zero     <= (res_next == '0);
            overflow <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
        end
    end
`endif

endmodule
